// File: rtl/dds_pkg.sv
// Shared DDS definitions: measurement FSM state encodings and the tuning-word width.
package dds_pkg;

  localparam int unsigned KW_WIDTH_DEF = 28;

  typedef logic [1:0] fsm_state_t;

  localparam fsm_state_t ST_IDLE = 2'd0;
  localparam fsm_state_t ST_ARM  = 2'd1;
  localparam fsm_state_t ST_GATE = 2'd2;
  localparam fsm_state_t ST_DONE = 2'd3;

  function automatic logic state_busy(input fsm_state_t s);
    return s != ST_IDLE;
  endfunction

endpackage

// File: rtl/freq_word_meter_if.sv
// Control/result bundle of the frequency meter; master drives stimulus, slave is the meter.
interface freq_word_meter_if #(
  parameter int unsigned GATE_LOG2 = 20,
  parameter int unsigned KW_WIDTH  = 28
) ();

  logic                sig_in;
  logic                start;
  logic                cont;
  logic                busy;
  logic                valid;
  logic                no_sig;
  logic [GATE_LOG2:0]  edge_cnt;
  logic [KW_WIDTH-1:0] kw_meas;

  modport master (
    output sig_in, start, cont,
    input  busy, valid, no_sig, edge_cnt, kw_meas
  );

  modport slave (
    input  sig_in, start, cont,
    output busy, valid, no_sig, edge_cnt, kw_meas
  );

endinterface

// File: rtl/sync_edge_det.sv
// Two-flop synchroniser for an asynchronous input plus registered rising-edge pulse.
module sync_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  logic meta;
  logic sync;
  logic prev;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta <= 1'b0;
      sync <= 1'b0;
      prev <= 1'b0;
      rise <= 1'b0;
    end else begin
      meta <= async_in;
      sync <= meta;
      prev <= sync;
      rise <= sync & ~prev;
    end
  end

endmodule

// File: rtl/freq_word_meter.sv
// Gated edge counter reporting input frequency as an equivalent DDS tuning word.
module freq_word_meter
  import dds_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned GATE_LOG2  = 20,
  parameter int unsigned KW_WIDTH   = KW_WIDTH_DEF
) (
  input logic              clk,
  input logic              rst,
  freq_word_meter_if.slave bus
);

  localparam int unsigned        SHIFT     = GATE_LOG2 - ADDR_WIDTH;
  localparam logic [GATE_LOG2:0] ONE       = 1;
  localparam logic [GATE_LOG2:0] CNT_MAX   = '1;
  localparam logic [GATE_LOG2:0] GATE_LAST = {1'b0, {GATE_LOG2{1'b1}}};

  fsm_state_t          state;
  logic                rise;
  logic [GATE_LOG2:0]  gate_cnt;
  logic [GATE_LOG2:0]  edge_acc;
  logic [GATE_LOG2:0]  edge_next;
  logic [GATE_LOG2:0]  edge_shift;
  logic [KW_WIDTH-1:0] kw_next;
  logic                gate_end;
  logic [GATE_LOG2:0]  edge_cnt_r;
  logic [KW_WIDTH-1:0] kw_r;
  logic                valid_r;
  logic                no_sig_r;

  sync_edge_det u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (bus.sig_in),
    .rise     (rise)
  );

  always_comb begin
    edge_next  = (rise && edge_acc != CNT_MAX) ? edge_acc + ONE : edge_acc;
    edge_shift = edge_next >> SHIFT;
    kw_next    = KW_WIDTH'(edge_shift);
    gate_end   = (gate_cnt == GATE_LAST);
  end

  // Results are captured on the transition into DONE so they are already
  // visible during the single DONE cycle in which valid is high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      gate_cnt   <= '0;
      edge_acc   <= '0;
      edge_cnt_r <= '0;
      kw_r       <= '0;
      valid_r    <= 1'b0;
      no_sig_r   <= 1'b0;
    end else begin
      valid_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start || bus.cont) begin
            state    <= ST_ARM;
            gate_cnt <= '0;
            edge_acc <= '0;
          end
        end
        ST_ARM: begin
          if (rise) begin
            state    <= ST_GATE;
            gate_cnt <= '0;
          end else if (gate_end) begin
            state      <= ST_DONE;
            edge_cnt_r <= '0;
            kw_r       <= '0;
            no_sig_r   <= 1'b1;
            valid_r    <= 1'b1;
          end else begin
            gate_cnt <= gate_cnt + ONE;
          end
        end
        ST_GATE: begin
          edge_acc <= edge_next;
          if (gate_end) begin
            state      <= ST_DONE;
            edge_cnt_r <= edge_next;
            kw_r       <= kw_next;
            no_sig_r   <= 1'b0;
            valid_r    <= 1'b1;
          end else begin
            gate_cnt <= gate_cnt + ONE;
          end
        end
        ST_DONE: begin
          gate_cnt <= '0;
          edge_acc <= '0;
          state    <= bus.cont ? ST_ARM : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.busy     = state_busy(state);
  assign bus.valid    = valid_r;
  assign bus.no_sig   = no_sig_r;
  assign bus.edge_cnt = edge_cnt_r;
  assign bus.kw_meas  = kw_r;

endmodule

// File: tb/tb_freq_word_meter.sv
// Directed self-checking bench for freq_word_meter with a short gate (2^11) and one-bit shift.
module tb_freq_word_meter;

  localparam int unsigned AW  = 10;
  localparam int unsigned GL  = 11;
  localparam int unsigned KWW = 28;
  localparam int          GATE = 1 << GL;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  freq_word_meter_if #(.GATE_LOG2(GL), .KW_WIDTH(KWW)) bus ();

  freq_word_meter #(
    .ADDR_WIDTH (AW),
    .GATE_LOG2  (GL),
    .KW_WIDTH   (KWW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_valid  = 0;
  int busy_drop = 0;
  bit mon_busy = 1'b0;

  int            gen_mode = 0;  // 0: accumulator MSB, 1: held low, 2: jittered toggle
  logic [AW-1:0] kw  = 64;
  logic [AW-1:0] acc = '0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    bus.sig_in = 1'b0;
    forever begin
      if (gen_mode == 2) begin
        #(77 + $urandom_range(0, 6));
        bus.sig_in = ~bus.sig_in;
      end else begin
        @(negedge clk);
        if (gen_mode == 0) begin
          acc = acc + kw;
          bus.sig_in = acc[AW-1];
        end else begin
          bus.sig_in = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (bus.valid) n_valid++;
    if (mon_busy && !bus.busy) busy_drop++;
  end

  task automatic wait_valid(input string tag, input bit do_start, output int cycles);
    bit seen;
    @(negedge clk);
    bus.start = do_start;
    cycles = 0;
    seen = 1'b0;
    while (cycles < 3 * GATE && !seen) begin
      @(negedge clk);
      bus.start = 1'b0;
      cycles++;
      if (bus.valid) seen = 1'b1;
    end
    check({tag, "_seen"}, seen, 1);
  endtask

  task automatic set_kw(input int k);
    kw = AW'(k);
    repeat (8) @(negedge clk);
  endtask

  task automatic expect_result(input string tag, input int e_edge, input int e_kw, input int e_nosig);
    check({tag, "_edge"}, bus.edge_cnt, e_edge);
    check({tag, "_kw"}, bus.kw_meas, e_kw);
    check({tag, "_nosig"}, bus.no_sig, e_nosig);
  endtask

  initial begin
    int cyc;
    int v0;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.cont = 1'b0;

    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy, 0);
    check("rst_valid", bus.valid, 0);
    expect_result("rst", 0, 0, 0);
    rst = 1'b0;

    // Period 16 -> 128 edges per 2048-cycle gate -> KW 64
    set_kw(64);
    wait_valid("p16", 1'b1, cyc);
    expect_result("p16", 128, 64, 0);
    @(negedge clk);
    check("p16_valid_pulse", bus.valid, 0);
    check("p16_busy_drop", bus.busy, 0);
    check("p16_hold", bus.edge_cnt, 128);

    set_kw(1);
    wait_valid("p1024", 1'b1, cyc);
    expect_result("p1024", 2, 1, 0);

    set_kw(512);
    wait_valid("p2", 1'b1, cyc);
    expect_result("p2", 1024, 512, 0);

    gen_mode = 1;
    repeat (8) @(negedge clk);
    wait_valid("nosig", 1'b1, cyc);
    check("nosig_latency", cyc, GATE + 1);
    expect_result("nosig", 0, 0, 1);

    gen_mode = 0;
    set_kw(64);
    bus.cont = 1'b1;
    wait_valid("cont1", 1'b0, cyc);
    expect_result("cont1", 128, 64, 0);
    kw = 128;
    mon_busy = 1'b1;
    wait_valid("cont2", 1'b0, cyc);
    check("cont2_kw_range", (bus.kw_meas >= 127 && bus.kw_meas <= 128), 1);
    wait_valid("cont3", 1'b0, cyc);
    expect_result("cont3", 256, 128, 0);
    bus.cont = 1'b0;
    mon_busy = 1'b0;
    check("cont_busy_held", busy_drop, 0);
    @(negedge clk);
    check("cont_stop_busy", bus.busy, 0);

    set_kw(64);
    @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (600) @(negedge clk);
    check("midgate_busy", bus.busy, 1);
    v0 = n_valid;
    rst = 1'b1;
    #1;
    check("arst_busy", bus.busy, 0);
    check("arst_valid", bus.valid, 0);
    expect_result("arst", 0, 0, 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("arst_no_valid", n_valid - v0, 0);
    check("arst_idle", bus.busy, 0);
    wait_valid("post_rst", 1'b1, cyc);
    expect_result("post_rst", 128, 64, 0);

    set_kw(32);
    @(negedge clk);
    v0 = n_valid;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (300) @(negedge clk);
    wait_valid("ign_start", 1'b1, cyc);
    expect_result("ign_start", 64, 32, 0);
    repeat (GATE + 200) @(negedge clk);
    check("ign_start_one_valid", n_valid - v0, 1);

    gen_mode = 2;
    repeat (20) @(negedge clk);
    wait_valid("jitter", 1'b1, cyc);
    check("jitter_kw_range", (bus.kw_meas >= 63 && bus.kw_meas <= 65), 1);
    check("jitter_nosig", bus.no_sig, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
